inst_sequencer: RTL and testbench
=================================

Name: inst_sequencer

Overview:
- Drives the instruction ROM index and replays each {valid, write, addr} entry as one cache request, holding it until the cache acknowledges.
- Stops at the first entry with valid=0, at the table end, or on an ack timeout.
- Sits between the instruction table and the cache under test; it is the top-level stimulus engine of the cache testbench/FPGA demo.

Parameters:
- INDEX_W, 4, width of instruction index (table depth = 2**INDEX_W).
- ADDR_W, 32, cache address width.
- DATA_W, 32, cache data width.
- WDATA_SEED, 32'hA5A5_0000, write data = addr[DATA_W-1:0] ^ WDATA_SEED.
- ACK_TIMEOUT, 255, max cycles to wait for cache_ack; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a run from index 0 when IDLE or DONE.
- index  out  INDEX_W  instruction ROM index.
- inst_valid  in  1  ROM valid bit for current index.
- inst_write  in  1  ROM write bit.
- inst_addr  in  ADDR_W  ROM address.
- cache_en  out  1  request strobe, held until ack.
- cache_we  out  1  1=write, 0=read.
- cache_addr  out  ADDR_W  request address.
- cache_din  out  DATA_W  write data.
- cache_ack  in  1  request complete; valid only while cache_en=1.
- cache_dout  in  DATA_W  read data, sampled on ack of a read.
- rdata_last  out  DATA_W  last read data captured.
- busy  out  1  run in progress.
- done  out  1  sticky; run finished.
- error  out  1  sticky; timeout occurred.

Behaviour:
- Reset: state=IDLE. index, cache_en, cache_we, cache_addr, cache_din, rdata_last, busy, done and error are all 0. Reset mid-request drops cache_en on the next edge with no completion.
- ROM is combinational: inst_* are valid in the same cycle index is driven.
- States:
  - IDLE: on start → FETCH with index=0, busy=1.
  - FETCH: one cycle. If inst_valid=0 → DONE. Else register cache_we=inst_write, cache_addr=inst_addr, cache_din=inst_addr^WDATA_SEED; set cache_en=1; clear the timeout counter; → REQ.
  - REQ: cache_en, we, addr and din are held stable. On cache_ack=1:
    - drop cache_en the next cycle;
    - if the request was a read, rdata_last<=cache_dout;
    - if index==2**INDEX_W-1 → DONE (no wrap), else index<=index+1 → FETCH.
    - If ACK_TIMEOUT!=0 and the counter reaches ACK_TIMEOUT without ack: cache_en<=0, error<=1 → DONE.
  - DONE: busy=0, done=1, index holds its last value. On start: clear done and error, index=0, → FETCH.
- An ack arriving in the same cycle as the timeout limit counts as success; error stays 0.
- cache_ack while cache_en=0 is ignored.
- start while busy is ignored.
- Latency per request: 1 FETCH cycle + N REQ cycles, where N ≥ 1 is the ack delay; back-to-back minimum is 2 cycles per instruction.

Optional Feature:
- Macro INST_SEQ_STATS_EN.
- When defined, add outputs:
  - req_cnt (16b): accepted requests.
  - wr_cnt (16b): writes.
  - stall_cnt (32b): REQ cycles with ack=0.
- Counters reset on rst and on start, and saturate at all-ones.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package inst_seq_pkg: state enum (IDLE, FETCH, REQ, DONE) and default WDATA_SEED.
- Sub-module ack_timer: loadable down-counter with enable and expire flag, used for the timeout.
- Statistics counters stay inline under the macro.

Test Plan:
- Table {W 0x18, R 0x4, invalid}, ack 1 cycle after en → two requests in order: write 0x18 with din=0x18^SEED, then read 0x4; done=1 after index 2; busy=0.
- Ack delayed 5 cycles on the first request → cache_en, addr and we stay stable for 5 cycles; stall_cnt=4 when stats are enabled.
- ACK_TIMEOUT=3, ack never asserted → cache_en drops after 3 REQ cycles; error=1, done=1, index=0.
- All 16 entries valid → 16 requests issued, index stops at 15 with no wrap, done=1.
- Read returning 0xDEAD_BEEF → rdata_last=0xDEAD_BEEF one cycle after ack; a following write leaves it unchanged.
- rst asserted during REQ of entry 3 → next cycle all outputs are 0 and state is IDLE; a subsequent start restarts from index 0.

Source files
------------

// File: rtl/inst_seq_pkg.sv
// Shared types for the instruction sequencer: FSM state encoding and default write-data seed.
package inst_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_REQ   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] WDATA_SEED_DEF = 32'hA5A5_0000;

  // Width of the timeout down-counter, which is loaded with ACK_TIMEOUT-1.
  function automatic int tmr_w(input int t);
    return (t < 3) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/inst_sequencer_ack_timer.sv
// ack_timer: loadable down-counter; o_expired is high once the count has run down to zero.
module ack_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  assign o_expired = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst)                    r_cnt <= '0;
    else if (i_load)            r_cnt <= i_load_val;
    else if (i_en && !o_expired) r_cnt <= r_cnt - 1'b1;
  end

endmodule

// File: rtl/inst_sequencer.sv
// Replays a ROM of {valid, write, addr} entries as cache requests, one at a time.
// Optional statistics outputs are enabled by defining INST_SEQ_STATS_EN.
module inst_sequencer
  import inst_seq_pkg::*;
#(
  parameter int                INDEX_W     = 4,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] WDATA_SEED  = DATA_W'(WDATA_SEED_DEF),
  parameter int                ACK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [INDEX_W-1:0] index,
  input  logic               inst_valid,
  input  logic               inst_write,
  input  logic [ADDR_W-1:0]  inst_addr,
  output logic               cache_en,
  output logic               cache_we,
  output logic [ADDR_W-1:0]  cache_addr,
  output logic [DATA_W-1:0]  cache_din,
  input  logic               cache_ack,
  input  logic [DATA_W-1:0]  cache_dout,
  output logic [DATA_W-1:0]  rdata_last,
  output logic               busy,
  output logic               done,
  output logic               error
`ifdef INST_SEQ_STATS_EN
  ,
  output logic [15:0]        req_cnt,
  output logic [15:0]        wr_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int          TW     = tmr_w(ACK_TIMEOUT);
  localparam bit          TMO_EN = (ACK_TIMEOUT != 0);
  localparam logic [TW-1:0] TLOAD = TW'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  state_t              r_state, w_nxt;
  logic [INDEX_W-1:0]  r_index;
  logic                r_en, r_we, r_busy, r_done, r_error;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_din, r_rdata;
  logic                w_go, w_issue, w_ack_ok, w_tmo, w_fin, w_last;
  logic                w_tmr_exp, w_expired;

  assign w_last    = (r_index == {INDEX_W{1'b1}});
  assign w_expired = TMO_EN & w_tmr_exp;
  assign w_fin     = (w_nxt == S_DONE) && (r_state != S_DONE);

  ack_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_issue),
    .i_load_val(TLOAD),
    .i_en      (r_state == S_REQ),
    .o_expired (w_tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // An ack in the same cycle the timer expires takes priority: the request succeeds.
  always_comb begin
    w_nxt    = r_state;
    w_go     = 1'b0;
    w_issue  = 1'b0;
    w_ack_ok = 1'b0;
    w_tmo    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: if (start) begin
        w_go  = 1'b1;
        w_nxt = S_FETCH;
      end
      S_FETCH: if (inst_valid) begin
        w_issue = 1'b1;
        w_nxt   = S_REQ;
      end else begin
        w_nxt = S_DONE;
      end
      S_REQ: if (cache_ack) begin
        w_ack_ok = 1'b1;
        w_nxt    = w_last ? S_DONE : S_FETCH;
      end else if (w_expired) begin
        w_tmo = 1'b1;
        w_nxt = S_DONE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_index <= '0;
      r_en    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      if (w_go) begin
        r_index <= '0;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end
      if (w_issue) begin
        r_en   <= 1'b1;
        r_we   <= inst_write;
        r_addr <= inst_addr;
        r_din  <= inst_addr[DATA_W-1:0] ^ WDATA_SEED;
      end
      if (w_ack_ok) begin
        r_en <= 1'b0;
        if (!r_we)  r_rdata <= cache_dout;
        if (!w_last) r_index <= r_index + 1'b1;
      end
      if (w_tmo) begin
        r_en    <= 1'b0;
        r_error <= 1'b1;
      end
      if (w_fin) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

`ifdef INST_SEQ_STATS_EN
  logic [15:0] r_req_cnt, r_wr_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_go) begin
      r_req_cnt   <= '0;
      r_wr_cnt    <= '0;
      r_stall_cnt <= '0;
    end else if (r_state == S_REQ) begin
      if (cache_ack) begin
        if (r_req_cnt != '1)        r_req_cnt <= r_req_cnt + 1'b1;
        if (r_we && r_wr_cnt != '1) r_wr_cnt  <= r_wr_cnt + 1'b1;
      end else if (r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign req_cnt   = r_req_cnt;
  assign wr_cnt    = r_wr_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

  assign index      = r_index;
  assign cache_en   = r_en;
  assign cache_we   = r_we;
  assign cache_addr = r_addr;
  assign cache_din  = r_din;
  assign rdata_last = r_rdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: one default instance plus one with ACK_TIMEOUT=3.
module tb_inst_sequencer;

  localparam logic [31:0] SEED = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0;
  logic [3:0]  index;
  logic        inst_valid, inst_write, cache_en, cache_we, cache_ack, busy, done, error;
  logic [31:0] inst_addr, cache_addr, cache_din, rdata_last;
  logic [31:0] rd_val = 32'h0;

  logic        start2 = 1'b0;
  logic [3:0]  index2;
  logic        inst_valid2, inst_write2, cache_en2, cache_we2, cache_ack2, busy2, done2, error2;
  logic [31:0] inst_addr2, cache_addr2, cache_din2, rdata_last2;

`ifdef INST_SEQ_STATS_EN
  logic [15:0] req_cnt, wr_cnt, req_cnt2, wr_cnt2;
  logic [31:0] stall_cnt, stall_cnt2;
`endif

  logic        rom_v [16], rom_w [16], rom2_v [16];
  logic [31:0] rom_a [16], rom2_a [16];
  int          dly [16];
  int          req_cyc = 0, req2_cyc = 0;
  logic        junk_ack = 1'b0, ack2_on = 1'b0;

  assign inst_valid  = rom_v[index];
  assign inst_write  = rom_w[index];
  assign inst_addr   = rom_a[index];
  assign cache_ack   = cache_en ? (req_cyc == dly[index] - 1) : junk_ack;
  assign inst_valid2 = rom2_v[index2];
  assign inst_write2 = 1'b0;
  assign inst_addr2  = rom2_a[index2];
  assign cache_ack2  = cache_en2 && ack2_on && (req2_cyc == 2);

  inst_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .index(index),
    .inst_valid(inst_valid), .inst_write(inst_write), .inst_addr(inst_addr),
    .cache_en(cache_en), .cache_we(cache_we), .cache_addr(cache_addr), .cache_din(cache_din),
    .cache_ack(cache_ack), .cache_dout(rd_val), .rdata_last(rdata_last),
    .busy(busy), .done(done), .error(error)
`ifdef INST_SEQ_STATS_EN
    , .req_cnt(req_cnt), .wr_cnt(wr_cnt), .stall_cnt(stall_cnt)
`endif
  );

  inst_sequencer #(.ACK_TIMEOUT(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .index(index2),
    .inst_valid(inst_valid2), .inst_write(inst_write2), .inst_addr(inst_addr2),
    .cache_en(cache_en2), .cache_we(cache_we2), .cache_addr(cache_addr2), .cache_din(cache_din2),
    .cache_ack(cache_ack2), .cache_dout(32'h0), .rdata_last(rdata_last2),
    .busy(busy2), .done(done2), .error(error2)
`ifdef INST_SEQ_STATS_EN
    , .req_cnt(req_cnt2), .wr_cnt(wr_cnt2), .stall_cnt(stall_cnt2)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
  } rq_t;

  rq_t  log_q[$];
  int   en_cnt = 0, en2_cnt = 0;
  logic unstable = 1'b0, p_en = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = '0;

  always @(posedge clk) begin
    req_cyc  <= (cache_en && !cache_ack) ? req_cyc + 1 : 0;
    req2_cyc <= (cache_en2 && !cache_ack2) ? req2_cyc + 1 : 0;
    if (cache_en && cache_ack) log_q.push_back('{cache_we, cache_addr, cache_din});
    if (cache_en) begin
      en_cnt++;
      if (p_en && (cache_addr != p_addr || cache_we != p_we)) unstable = 1'b1;
    end
    if (cache_en2) en2_cnt++;
    p_en = cache_en; p_addr = cache_addr; p_we = cache_we;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic pulse(input bit second);
    @(posedge clk); #1;
    if (second) start2 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit second);
    int k = 0;
    while (!(second ? done2 : done) && k < 300) begin @(negedge clk); k++; end
    chk(tag, 64'(k < 300), 64'd1);
  endtask

  task automatic clr_rom;
    for (int i = 0; i < 16; i++) begin
      rom_v[i] = 1'b0; rom_w[i] = 1'b0; rom_a[i] = '0; dly[i] = 1;
      rom2_v[i] = 1'b0; rom2_a[i] = '0;
    end
  endtask

  initial begin
    clr_rom();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_index", 64'(index), 64'd0);
    chk("rst_en",    64'(cache_en), 64'd0);
    chk("rst_flags", 64'({busy, done, error, cache_we}), 64'd0);
    chk("rst_data",  64'({cache_addr, cache_din}), 64'd0);

    // Two requests; stray acks while cache_en is low must be ignored.
    rom_v[0] = 1; rom_w[0] = 1; rom_a[0] = 32'h18;
    rom_v[1] = 1; rom_w[1] = 0; rom_a[1] = 32'h4;
    rd_val = 32'h1234_5678; junk_ack = 1'b1;
    log_q.delete();
    pulse(0);
    wait_done("t1_done_to", 0);
    junk_ack = 1'b0;
    chk("t1_nreq", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      chk("t1_r0", 64'({log_q[0].we, log_q[0].addr}), {31'd0, 1'b1, 32'h18});
      chk("t1_r0_din", 64'(log_q[0].din), 64'hA5A5_0018);
      chk("t1_r1", 64'({log_q[1].we, log_q[1].addr}), 64'h4);
    end
    chk("t1_index", 64'(index), 64'd2);
    chk("t1_flags", 64'({busy, done, error}), 64'b010);
    chk("t1_rdata", 64'(rdata_last), 64'h1234_5678);

    // Slow ack; a start pulse mid-run must not restart the table.
    clr_rom();
    rom_v[0] = 1; rom_a[0] = 32'h40; dly[0] = 5;
    log_q.delete(); en_cnt = 0; unstable = 1'b0;
    pulse(0);
    pulse(0);
    wait_done("t2_done_to", 0);
    chk("t2_en_cycles", 64'(en_cnt), 64'd5);
    chk("t2_stable", 64'(unstable), 64'd0);
    chk("t2_nreq", 64'(log_q.size()), 64'd1);
    chk("t2_index", 64'(index), 64'd1);
`ifdef INST_SEQ_STATS_EN
    chk("t2_stall", 64'(stall_cnt), 64'd4);
    chk("t2_req", 64'({req_cnt, wr_cnt}), 64'h0001_0000);
`endif

    // Timeout instance: no ack, then ack exactly on the limit cycle.
    rom2_v[0] = 1; rom2_a[0] = 32'h8;
    ack2_on = 1'b0; en2_cnt = 0;
    pulse(1);
    wait_done("t3_done_to", 1);
    chk("t3_en_cycles", 64'(en2_cnt), 64'd3);
    chk("t3_flags", 64'({busy2, done2, error2, cache_en2}), 64'b0110);
    chk("t3_index", 64'(index2), 64'd0);
    ack2_on = 1'b1; en2_cnt = 0;
    pulse(1);
    chk("t3_restart_clr", 64'({done2, error2}), 64'd0);
    wait_done("t3b_done_to", 1);
    chk("t3b_error", 64'(error2), 64'd0);
    chk("t3b_en_cycles", 64'(en2_cnt), 64'd3);
    chk("t3b_index", 64'(index2), 64'd1);

    // Full table: 16 requests, index parks at 15.
    for (int i = 0; i < 16; i++) begin
      rom_v[i] = 1; rom_w[i] = i[0]; rom_a[i] = 32'h1000 + 32'(i * 4); dly[i] = 1;
    end
    log_q.delete();
    pulse(0);
    wait_done("t4_done_to", 0);
    repeat (4) @(negedge clk);
    chk("t4_nreq", 64'(log_q.size()), 64'd16);
    if (log_q.size() == 16)
      chk("t4_last", 64'({log_q[15].addr, log_q[15].din}), 64'h0000_103C_A5A5_103C);
    chk("t4_index", 64'(index), 64'd15);
    chk("t4_flags", 64'({busy, done}), 64'b01);

    // Read capture, then a write must leave rdata_last alone.
    clr_rom();
    rom_v[0] = 1; rom_w[0] = 0; rom_a[0] = 32'h100;
    rom_v[1] = 1; rom_w[1] = 1; rom_a[1] = 32'h104;
    rd_val = 32'hDEAD_BEEF;
    pulse(0);
    begin
      int k = 0;
      while (!(cache_en && cache_ack) && k < 50) begin @(negedge clk); k++; end
      chk("t5_ack_to", 64'(k < 50), 64'd1);
    end
    @(negedge clk);
    chk("t5_rdata", 64'(rdata_last), 64'hDEAD_BEEF);
    rd_val = 32'h0;
    wait_done("t5_done_to", 0);
    chk("t5_rdata_hold", 64'(rdata_last), 64'hDEAD_BEEF);

    // Reset while entry 3 is outstanding.
    for (int i = 0; i < 16; i++) begin
      rom_v[i] = 1; rom_w[i] = i[0]; rom_a[i] = 32'h1000 + 32'(i * 4); dly[i] = 1;
    end
    dly[3] = 10; rd_val = 32'h55;
    pulse(0);
    begin
      int k = 0;
      while (!(index == 4'd3 && cache_en) && k < 50) begin @(negedge clk); k++; end
      chk("t6_req3_to", 64'(k < 50), 64'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_outs", 64'({index, cache_en, cache_we, busy, done, error}), 64'd0);
    chk("t6_rst_data", 64'({cache_addr, cache_din}), 64'd0);
    chk("t6_rst_rdata", 64'(rdata_last), 64'd0);
    rst = 1'b0; dly[3] = 1;
    log_q.delete();
    pulse(0);
    @(negedge clk);
    chk("t6_restart", 64'({index, busy}), 64'h01);
    wait_done("t6_done_to", 0);
    chk("t6_nreq", 64'(log_q.size()), 64'd16);
    if (log_q.size() > 0) chk("t6_first", 64'(log_q[0].addr), 64'h1000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
